// File: rtl/mult_mon_pkg.sv
// ---------------------------------------------------------------------------
// mult_mon_pkg
// Shared definitions for the approximate-multiplier error monitor:
//   - default operand / counter / accumulator widths
//   - monitor FSM state encoding (RUN, DRAIN, DONE)
//   - saturating add used by every statistic accumulator
// ---------------------------------------------------------------------------
package mult_mon_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_SUM_W = 32;

    // Widest accumulator the saturating adder supports.
    localparam int ACC_MAX_W = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic                 ovf;
        logic [ACC_MAX_W-1:0] sum;
    } sat_sum_t;

    // Adds inc to acc and clamps to the all-ones value of a w-bit field.
    // ovf flags that the true sum did not fit, so callers can keep a
    // sticky saturation indicator.
    function automatic sat_sum_t sat_add(
        input logic [ACC_MAX_W-1:0] acc,
        input logic [ACC_MAX_W-1:0] inc,
        input int                   w
    );
        sat_sum_t             res;
        logic [ACC_MAX_W:0]   full;
        logic [ACC_MAX_W-1:0] lim;
        // Shifting all-ones left by w leaves w zero LSBs; inverting gives
        // the w-bit maximum (and all-ones once w reaches ACC_MAX_W).
        lim  = ~({ACC_MAX_W{1'b1}} << w);
        full = {1'b0, acc} + {1'b0, inc};
        if (full > {1'b0, lim}) begin
            res.ovf = 1'b1;
            res.sum = lim;
        end else begin
            res.ovf = 1'b0;
            res.sum = full[ACC_MAX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_abs_err.sv
// ---------------------------------------------------------------------------
// mult_abs_err
// Combinational comparison of an approximate product against the exact one.
// Ports:
//   exact   in  2*WIDTH  exact unsigned product
//   y       in  2*WIDTH  approximate product under test
//   abs_err out 2*WIDTH  |y - exact|
//   over    out 1        y > exact
//   mism    out 1        y != exact
// ---------------------------------------------------------------------------
module mult_abs_err
    import mult_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] exact,
    input  logic [2*WIDTH-1:0] y,
    output logic [2*WIDTH-1:0] abs_err,
    output logic               over,
    output logic               mism
);

    // One extra bit so the difference of two unsigned 2*WIDTH values is
    // always representable; its magnitude then fits back into 2*WIDTH.
    logic signed [2*WIDTH:0] diff;
    logic signed [2*WIDTH:0] neg_diff;

    assign diff     = $signed({1'b0, y}) - $signed({1'b0, exact});
    assign neg_diff = -diff;

    assign abs_err = diff[2*WIDTH] ? neg_diff[2*WIDTH-1:0] : diff[2*WIDTH-1:0];
    assign mism    = (diff != '0);
    assign over    = !diff[2*WIDTH] && mism;

endmodule

// File: rtl/mult_err_monitor.sv
// ---------------------------------------------------------------------------
// mult_err_monitor
// At-speed error monitor for approximate WIDTH x WIDTH multipliers. Accepts a
// valid/ready stream of (a, b, y) samples, recomputes a*b and accumulates
// error statistics. A sample flagged last ends the run: the pipeline drains,
// done pulses, and the statistics stay frozen until clear.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   clear                      sync flush / zero stats / back to RUN
//   in_valid, in_ready         sample handshake
//   in_a, in_b, in_y, in_last  operands, approximate product, end-of-run mark
//   sample_cnt, mismatch_cnt,  saturating sample / mismatch /
//   over_cnt                   over-estimate counters
//   err_sum                    saturating sum of |y - a*b|
//   err_max, max_a, max_b      worst error and the operands that caused it
//   sat                        sticky: some statistic saturated
//   done                       one-cycle pulse when the last sample lands
//   stats_valid                high while statistics are frozen (DONE)
// ---------------------------------------------------------------------------
module mult_err_monitor
    import mult_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_y,
    input  logic               in_last,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [CNT_W-1:0]   over_cnt,
    output logic [SUM_W-1:0]   err_sum,
    output logic [2*WIDTH-1:0] err_max,
    output logic [WIDTH-1:0]   max_a,
    output logic [WIDTH-1:0]   max_b,
    output logic               sat,
    output logic               done,
    output logic               stats_valid
);

    mon_state_t state, state_next;
    logic       accept;

    logic [WIDTH-1:0]   a_p1, b_p1;
    logic [2*WIDTH-1:0] y_p1, exact_p1;
    logic               last_p1, vld_p1;

    logic [WIDTH-1:0]   a_p2, b_p2;
    logic [2*WIDTH-1:0] abs_err_p2;
    logic               over_p2, mism_p2, last_p2, vld_p2;

    logic [2*WIDTH-1:0] abs_err;
    logic               over, mism;

    sat_sum_t cnt_nx, mism_nx, over_nx, sum_nx;

    // FSM: state register + next-state / handshake logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            RUN: begin
                // Holding in_ready low during clear makes clear win over a
                // transfer in the same cycle; gating with rst_n keeps every
                // output low while reset is asserted.
                in_ready = rst_n && !clear;
                if (in_valid && in_ready && in_last) state_next = DRAIN;
            end
            DRAIN:   if (vld_p2 && last_p2) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
        if (clear) state_next = RUN;
    end

    assign accept      = in_valid && in_ready;
    assign stats_valid = (state == DONE);

    // Pipeline valids: the only pipeline state that needs reset or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (clear) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1: capture sample, form exact product
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1     <= in_a;
            b_p1     <= in_b;
            y_p1     <= in_y;
            last_p1  <= in_last;
            exact_p1 <= {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
        end
    end

    // Stage 2: signed compare against exact product
    mult_abs_err #(
        .WIDTH (WIDTH)
    ) u_abs_err (
        .exact   (exact_p1),
        .y       (y_p1),
        .abs_err (abs_err),
        .over    (over),
        .mism    (mism)
    );

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            a_p2       <= a_p1;
            b_p2       <= b_p1;
            abs_err_p2 <= abs_err;
            over_p2    <= over;
            mism_p2    <= mism;
            last_p2    <= last_p1;
        end
    end

    // Stage 3: saturating accumulation of statistics
    always_comb begin
        cnt_nx  = sat_add(64'(sample_cnt),   64'(1'b1),       CNT_W);
        mism_nx = sat_add(64'(mismatch_cnt), 64'(mism_p2),    CNT_W);
        over_nx = sat_add(64'(over_cnt),     64'(over_p2),    CNT_W);
        sum_nx  = sat_add(64'(err_sum),      64'(abs_err_p2), SUM_W);
    end

    // Clamped results never exceed the field width, so the upper bits of
    // the generic 64-bit adder output carry no information.
    logic unused_hi;
    assign unused_hi = ^{cnt_nx.sum[ACC_MAX_W-1:CNT_W], mism_nx.sum[ACC_MAX_W-1:CNT_W],
                         over_nx.sum[ACC_MAX_W-1:CNT_W], sum_nx.sum[ACC_MAX_W-1:SUM_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            over_cnt     <= '0;
            err_sum      <= '0;
            err_max      <= '0;
            max_a        <= '0;
            max_b        <= '0;
            sat          <= 1'b0;
            done         <= 1'b0;
        end else if (clear) begin
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            over_cnt     <= '0;
            err_sum      <= '0;
            err_max      <= '0;
            max_a        <= '0;
            max_b        <= '0;
            sat          <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (vld_p2) begin
                sample_cnt   <= cnt_nx.sum[CNT_W-1:0];
                mismatch_cnt <= mism_nx.sum[CNT_W-1:0];
                over_cnt     <= over_nx.sum[CNT_W-1:0];
                err_sum      <= sum_nx.sum[SUM_W-1:0];
                sat          <= sat | cnt_nx.ovf | mism_nx.ovf | over_nx.ovf | sum_nx.ovf;
                // Strictly greater: the first sample reaching a new worst
                // case keeps its operands on ties.
                if (abs_err_p2 > err_max) begin
                    err_max <= abs_err_p2;
                    max_a   <= a_p2;
                    max_b   <= b_p2;
                end
                done <= last_p2;
            end
        end
    end

endmodule

// File: doc/mult_err_monitor.md
# mult_err_monitor

Synthesizable on-chip error monitor for the approximate 8-bit multipliers. It sits downstream of the multiplier wrapper and consumes a valid/ready stream of (operand A, operand B, approximate product) samples. For each sample it recomputes the exact product and accumulates sample count, mismatch count, over-estimate count, absolute-error sum and worst-case error with its operands. A run ends on a marked last sample, after which the statistics are frozen for readout, enabling at-speed self-test without a simulator.

## Interface
- WIDTH, 8, operand width; products are 2*WIDTH bits
- CNT_W, 16, width of sample/mismatch/overestimate counters
- SUM_W, 32, width of absolute-error accumulator
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low; one clock, async active-low reset (fixed)
- clear  in  1  synchronous: flush pipeline, zero statistics, return to RUN
- in_valid  in  1  sample valid
- in_ready  out  1  monitor can accept; transfer on in_valid & in_ready
- in_a, in_b  in  WIDTH  operands
- in_y  in  2*WIDTH  approximate product under test
- in_last  in  1  final sample of run
- sample_cnt, mismatch_cnt, over_cnt  out  CNT_W  samples, samples with y≠exact, samples with y>exact
- err_sum  out  SUM_W  sum of |y − exact|
- err_max  out  2*WIDTH  largest |y − exact|
- max_a, max_b  out  WIDTH  operands producing err_max
- sat  out  1  sticky: some counter or err_sum saturated
- done  out  1  one-cycle pulse when last sample has been accumulated
- stats_valid  out  1  high in DONE state

## Operation
- FSM states: RUN (in_ready=1), DRAIN (last accepted, in_ready=0, pipeline empties), DONE (in_ready=0, stats frozen, stats_valid=1).
- RUN→DRAIN on accepted sample with in_last=1; DRAIN→DONE when that sample is accumulated (done pulses on that cycle); DONE holds until clear.
- clear from any state: next state RUN, both pipeline stage valids cleared, all stats, sat and done zeroed. clear has priority over a same-cycle transfer; in_ready=0 while clear=1.
- Stage 1: register a, b, y, last; exact = a*b (2*WIDTH, unsigned). Stage 2: diff = y − exact in 2*WIDTH+1 signed bits; abs_err = |diff|; over = diff>0; mism = diff≠0. Stage 3: accumulate.
- Counters and err_sum saturate at all-ones (no wrap); sat sets when any would overflow, sticky until clear/reset.
- err_max/max_a/max_b update only on strictly greater abs_err (first worst case wins ties).
- Zero operands handled exactly: 0*b=0; any nonzero y counts as mismatch and over-estimate.
- Reset: all outputs 0, state RUN; in_ready=1 after reset deasserts.

## Timing
- Sample accepted at edge k is reflected in stats after edge k+2 (2-cycle latency, full throughput, one sample/cycle).
- For last sample at edge k: in_ready=0 from cycle after k; done=1 for the cycle following edge k+2; stats_valid=1 from that same cycle.
- No backpressure inside the pipeline; in_ready depends only on state and clear.
- Reset mid-run discards in-flight samples immediately (async).

## Structure
- Package mult_mon_pkg: state enum (RUN, DRAIN, DONE), default WIDTH/CNT_W/SUM_W constants, saturating-add function.
- Sub-module mult_abs_err: combinational stage-2 datapath (exact product compare, abs_err, over, mism), instantiated once; FSM, pipeline registers and accumulators in top.

## Test plan
- Exact samples: (255,255,65025), (17,17,289) with last on second → sample_cnt=2, mismatch_cnt=0, err_sum=0, done pulse 2 cycles after last transfer.
- Errors: (23,67,1500) then (67,23,1550,last) → exact 1541; mismatch_cnt=2, over_cnt=1, err_sum=50, err_max=41, max_a=23, max_b=67.
- Zeros: (0,19,0),(19,0,4),(0,0,0,last) → mismatch_cnt=1, over_cnt=1, err_sum=4, err_max=4, max_a=19, max_b=0.
- Protocol: in_ready=0 in DRAIN/DONE, valid samples held there are not counted; clear in DONE → all stats 0, in_ready=1 next cycle; clear during DRAIN drops in-flight last, no done pulse.
- Saturation with SUM_W=8: five samples of |err|=100 → err_sum=255, sat=1, sample_cnt=5.
- Async rst_n low mid-DRAIN → all outputs 0 immediately, state RUN after release.
